// File: rtl/tmds_serializer_gen_if.sv
// Parallel word handshake into the TMDS serializer.
// Master drives words, slave returns ready.
interface tmds_serializer_gen_if #(
  parameter int NUM_CH = 3,
  parameter int WORD_W = 10
);
  logic [NUM_CH*WORD_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/tmds_serializer_gen.sv
// Multi-lane word serializer with 2-deep input FIFO,
// idle-word insertion and forwarded word-rate clock.
module tmds_serializer_gen #(
  parameter int NUM_CH = 3,
  parameter int WORD_W = 10,
  parameter bit MSB_FIRST = 1'b0,
  parameter logic [WORD_W-1:0] IDLE_WORD =
    WORD_W'(10'b1101010100)
) (
  input  logic              clk_fast,
  input  logic              rst_n,
  tmds_serializer_gen_if.slave in_if,
  input  logic              underrun_clr,
  output logic [NUM_CH-1:0] ser_p,
  output logic [NUM_CH-1:0] ser_n,
  output logic              clk_p,
  output logic              clk_n,
  output logic              frame_strobe,
  output logic              underrun
);
  localparam int DW = NUM_CH * WORD_W;
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0] HALF = CW'(WORD_W / 2);

  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_nxt;
  logic          load;
  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          live;
  logic          push;
  logic          pop;
  logic [DW-1:0] load_word;

  assign load    = (bit_cnt == LAST);
  assign bit_nxt = load ? '0 : bit_cnt + 1'b1;

  // in_ready held low until the first edge after reset
  assign in_if.in_ready = live && (count != 2'd2);
  assign push = in_if.in_valid && in_if.in_ready;
  // pop decided on pre-edge occupancy: no same-edge bypass
  assign pop  = load && (count != 2'd0);

  assign load_word = pop ? mem[rd_ptr]
                         : {NUM_CH{IDLE_WORD}};

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      live         <= 1'b0;
      clk_p        <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      mem[0]       <= '0;
      mem[1]       <= '0;
    end else begin
      live         <= 1'b1;
      bit_cnt      <= bit_nxt;
      frame_strobe <= load;
      clk_p        <= (bit_nxt < HALF);
      if (push) begin
        mem[wr_ptr] <= in_if.in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
      if (load && count == 2'd0)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [WORD_W-1:0] sr;

    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)
        sr <= '0;
      else if (load)
        sr <= load_word[k*WORD_W +: WORD_W];
      else if (MSB_FIRST)
        sr <= sr << 1;
      else
        sr <= sr >> 1;
    end

    assign ser_p[k] = MSB_FIRST ? sr[WORD_W-1] : sr[0];
  end

  assign ser_n = ~ser_p;
  assign clk_n = ~clk_p;
endmodule

// File: tb/tb_tmds_serializer_gen.sv
// Scoreboard bench for tmds_serializer_gen:
// default, MSB-first and 4x8 instances on one clock.
module tb_tmds_serializer_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic clr = 1'b0;

  tmds_serializer_gen_if #(.NUM_CH(3), .WORD_W(10)) ifa ();
  tmds_serializer_gen_if #(.NUM_CH(3), .WORD_W(10)) ifb ();
  tmds_serializer_gen_if #(.NUM_CH(4), .WORD_W(8))  ifc ();

  logic [2:0] sp_a, sn_a, sp_b, sn_b;
  logic [3:0] sp_c, sn_c;
  logic ckp_a, ckn_a, fs_a, ur_a;
  logic ckp_b, ckn_b, fs_b, ur_b;
  logic ckp_c, ckn_c, fs_c, ur_c;

  tmds_serializer_gen u_a (
    .clk_fast(clk), .rst_n(rst_n), .in_if(ifa),
    .underrun_clr(clr), .ser_p(sp_a), .ser_n(sn_a),
    .clk_p(ckp_a), .clk_n(ckn_a),
    .frame_strobe(fs_a), .underrun(ur_a)
  );

  tmds_serializer_gen #(.MSB_FIRST(1'b1)) u_b (
    .clk_fast(clk), .rst_n(rst_n), .in_if(ifb),
    .underrun_clr(clr), .ser_p(sp_b), .ser_n(sn_b),
    .clk_p(ckp_b), .clk_n(ckn_b),
    .frame_strobe(fs_b), .underrun(ur_b)
  );

  tmds_serializer_gen #(.NUM_CH(4), .WORD_W(8)) u_c (
    .clk_fast(clk), .rst_n(rst_n), .in_if(ifc),
    .underrun_clr(clr), .ser_p(sp_c), .ser_n(sn_c),
    .clk_p(ckp_c), .clk_n(ckn_c),
    .frame_strobe(fs_c), .underrun(ur_c)
  );

  localparam logic [9:0] IDLE = 10'b1101010100;

  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] sbq [$];

  typedef struct packed {
    logic [3:0] sp;
    logic [3:0] sn;
    logic fs;
    logic ckp;
    logic ckn;
  } smp_t;

  function automatic logic [63:0] pk(
    input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic smp_t get(input int sel);
    smp_t s;
    case (sel)
      0: s = {1'b0, sp_a, 1'b1, sn_a, fs_a, ckp_a, ckn_a};
      1: s = {1'b0, sp_b, 1'b1, sn_b, fs_b, ckp_b, ckn_b};
      default: s = {sp_c, sn_c, fs_c, ckp_c, ckn_c};
    endcase
    return s;
  endfunction

  // waits for a strobe, then collects one word per lane
  task automatic cap(input int sel,
    output logic [63:0] w, output int wc, output bit to,
    output bit nbad, output int xs, output bit pre_nz,
    output logic [15:0] ck, output bit prev_ck);
    int ww;
    int b;
    smp_t s;
    ww = (sel == 2) ? 8 : 10;
    w = '0; wc = 0; to = 0; nbad = 0; xs = 0;
    pre_nz = 0; ck = '0; prev_ck = 0;
    s = get(sel);
    do begin
      prev_ck = s.ckp;
      if (s.sp != 4'h0) pre_nz = 1;
      @(negedge clk);
      wc++;
      s = get(sel);
      if (s.sn !== ~s.sp || s.ckn !== ~s.ckp) nbad = 1;
    end while (!s.fs && wc < 60);
    if (!s.fs) begin
      to = 1;
      return;
    end
    for (int i = 0; i < ww; i++) begin
      if (i > 0) begin
        @(negedge clk);
        s = get(sel);
        if (s.sn !== ~s.sp || s.ckn !== ~s.ckp) nbad = 1;
        if (s.fs) xs++;
      end
      b = (sel == 1) ? ww - 1 - i : i;
      for (int k = 0; k < 4; k++) w[k*16 + b] = s.sp[k];
      ck[i] = s.ckp;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    ifa.in_data = '0; ifb.in_data = '0; ifc.in_data = '0;
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed_a(input logic [29:0] a, b, c,
    output bit stall);
    logic [29:0] ws [3];
    int n;
    ws[0] = a; ws[1] = b; ws[2] = c;
    stall = 0;
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      ifa.in_data = ws[i];
      while (!ifa.in_ready && n < 100) begin
        stall = 1;
        @(negedge clk);
        n++;
      end
      if (ifa.in_ready)
        sbq.push_back(pk({6'h0, ws[i][9:0]},
          {6'h0, ws[i][19:10]}, {6'h0, ws[i][29:20]}, 16'h0));
      @(negedge clk);
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    ifa.in_data = '0; ifb.in_data = '0; ifc.in_data = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (sp_a !== 3'b000) $display("FAIL rst_ser_p got %b want 000", sp_a); else n_pass++;
    n_chk++; if (sn_a !== 3'b111) $display("FAIL rst_ser_n got %b want 111", sn_a); else n_pass++;
    n_chk++; if ({ckp_a, ckn_a} !== 2'b01) $display("FAIL rst_clk got %b want 01", {ckp_a, ckn_a}); else n_pass++;
    n_chk++; if ({fs_a, ur_a} !== 2'b00) $display("FAIL rst_fs_ur got %b want 00", {fs_a, ur_a}); else n_pass++;
    n_chk++; if (ifa.in_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ifa.in_ready); else n_pass++;
    n_chk++; if (sn_c !== 4'hF) $display("FAIL rst_ser_n_c got %h want f", sn_c); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++; if (ifa.in_ready !== 1'b0) $display("FAIL rel_ready_early got %b want 0", ifa.in_ready); else n_pass++;
    @(negedge clk);
    n_chk++; if (ifa.in_ready !== 1'b1) $display("FAIL rel_ready_edge1 got %b want 1", ifa.in_ready); else n_pass++;
  endtask

  task automatic test_defaults();
    logic [63:0] w, e;
    logic [15:0] ck;
    int wc, xs;
    bit to, nb, pz, pc;
    do_reset();
    @(negedge clk);
    ifa.in_data = {10'h155, 10'h000, 10'h3FF};
    ifa.in_valid = 1'b1;
    if (ifa.in_ready) sbq.push_back(pk(16'h3FF, 16'h0, 16'h155, 16'h0));
    @(negedge clk);
    ifa.in_valid = 1'b0;
    cap(0, w, wc, to, nb, xs, pz, ck, pc);
    e = (sbq.size() > 0) ? sbq.pop_front() : '1;
    n_chk++; if (to) $display("FAIL dflt_timeout got no strobe want strobe"); else n_pass++;
    n_chk++; if (w !== e) $display("FAIL dflt_word got %h want %h", w, e); else n_pass++;
    n_chk++; if (wc !== 8) $display("FAIL dflt_first_load got %0d want 8", wc); else n_pass++;
    n_chk++; if (pz) $display("FAIL dflt_pre_zero got nonzero want zero"); else n_pass++;
    n_chk++; if (xs !== 0) $display("FAIL dflt_strobe_once got %0d extra want 0", xs); else n_pass++;
    n_chk++; if (nb) $display("FAIL dflt_ser_n got mismatch want inverse"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit stall;
    do_reset();
    @(negedge clk);
    fork
      feed_a({10'h004, 10'h002, 10'h001},
             {10'h2AA, 10'h155, 10'h3E0},
             {10'h1C7, 10'h30C, 10'h0F0}, stall);
      begin
        logic [63:0] w, e;
        logic [15:0] ck;
        int wc, xs;
        bit to, nb, pz, pc;
        for (int j = 0; j < 3; j++) begin
          cap(0, w, wc, to, nb, xs, pz, ck, pc);
          e = (sbq.size() > 0) ? sbq.pop_front() : '1;
          n_chk++; if (to || w !== e) $display("FAIL b2b_word%0d got %h want %h", j, w, e); else n_pass++;
          n_chk++; if (wc !== ((j == 0) ? 9 : 1)) $display("FAIL b2b_gap%0d got %0d want %0d", j, wc, (j == 0) ? 9 : 1); else n_pass++;
        end
      end
    join
    n_chk++; if (!stall) $display("FAIL b2b_ready_drop got 0 want 1"); else n_pass++;
    n_chk++; if (ur_a !== 1'b0) $display("FAIL b2b_underrun got %b want 0", ur_a); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [63:0] w, e;
    logic [15:0] ck;
    int wc, xs;
    bit to, nb, pz, pc;
    cap(0, w, wc, to, nb, xs, pz, ck, pc);
    e = pk({6'h0, IDLE}, {6'h0, IDLE}, {6'h0, IDLE}, 16'h0);
    n_chk++; if (to || w !== e) $display("FAIL ur_idle got %h want %h", w, e); else n_pass++;
    n_chk++; if (ur_a !== 1'b1) $display("FAIL ur_set got %b want 1", ur_a); else n_pass++;
    clr = 1'b1;
    @(negedge clk);
    n_chk++; if (ur_a !== 1'b1) $display("FAIL ur_set_wins got %b want 1", ur_a); else n_pass++;
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_chk++; if (ur_a !== 1'b0) $display("FAIL ur_clear got %b want 0", ur_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] w, e;
    logic [15:0] ck;
    int wc, xs;
    bit to, nb, pz, pc, stall;
    do_reset();
    @(negedge clk);
    feed_a({10'h111, 10'h222, 10'h333},
           {10'h0AA, 10'h0BB, 10'h0CC},
           {10'h3C3, 10'h2D2, 10'h1E1}, stall);
    repeat (3) @(negedge clk);
    n_chk++; if (ifa.in_ready !== 1'b0) $display("FAIL mid_full got %b want 0", ifa.in_ready); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({sp_a, sn_a} !== 6'b000111) $display("FAIL mid_ser got %b want 000111", {sp_a, sn_a}); else n_pass++;
    n_chk++; if ({ckp_a, ckn_a, fs_a, ur_a} !== 4'b0100) $display("FAIL mid_ctl got %b want 0100", {ckp_a, ckn_a, fs_a, ur_a}); else n_pass++;
    n_chk++; if (ifa.in_ready !== 1'b0) $display("FAIL mid_ready got %b want 0", ifa.in_ready); else n_pass++;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cap(0, w, wc, to, nb, xs, pz, ck, pc);
    e = pk({6'h0, IDLE}, {6'h0, IDLE}, {6'h0, IDLE}, 16'h0);
    n_chk++; if (to || w !== e) $display("FAIL mid_idle got %h want %h", w, e); else n_pass++;
    n_chk++; if (wc !== 10) $display("FAIL mid_first_load got %0d want 10", wc); else n_pass++;
    n_chk++; if (pz) $display("FAIL mid_pre_zero got nonzero want zero"); else n_pass++;
  endtask

  task automatic test_msb_first();
    logic [63:0] w, e;
    logic [15:0] ck;
    int wc, xs;
    bit to, nb, pz, pc;
    do_reset();
    @(negedge clk);
    ifb.in_data = {3{10'h200}};
    ifb.in_valid = 1'b1;
    if (ifb.in_ready) sbq.push_back(pk(16'h200, 16'h200, 16'h200, 16'h0));
    @(negedge clk);
    ifb.in_valid = 1'b0;
    cap(1, w, wc, to, nb, xs, pz, ck, pc);
    e = (sbq.size() > 0) ? sbq.pop_front() : '1;
    n_chk++; if (to || w !== e) $display("FAIL msb_word got %h want %h", w, e); else n_pass++;
    n_chk++; if (ck !== 16'h001F) $display("FAIL msb_clk_p got %h want 001f", ck); else n_pass++;
    n_chk++; if (pc !== 1'b0) $display("FAIL msb_clk_rise got prev %b want 0", pc); else n_pass++;
    n_chk++; if (nb) $display("FAIL msb_ser_n got mismatch want inverse"); else n_pass++;
  endtask

  task automatic test_narrow();
    logic [63:0] w, e;
    logic [15:0] ck;
    int wc, xs;
    bit to, nb, pz, pc;
    do_reset();
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data = {8'h81, 8'hF0, 8'h3C, 8'hA5};
    if (ifc.in_ready) sbq.push_back(pk(16'hA5, 16'h3C, 16'hF0, 16'h81));
    @(negedge clk);
    ifc.in_data = {8'h12, 8'h34, 8'h56, 8'h78};
    if (ifc.in_ready) sbq.push_back(pk(16'h78, 16'h56, 16'h34, 16'h12));
    @(negedge clk);
    ifc.in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cap(2, w, wc, to, nb, xs, pz, ck, pc);
      e = (sbq.size() > 0) ? sbq.pop_front() : '1;
      n_chk++; if (to || w !== e) $display("FAIL nar_word%0d got %h want %h", j, w, e); else n_pass++;
      n_chk++; if (wc !== ((j == 0) ? 5 : 1)) $display("FAIL nar_period%0d got %0d want %0d", j, wc, (j == 0) ? 5 : 1); else n_pass++;
      n_chk++; if (ck !== 16'h000F) $display("FAIL nar_clk_p%0d got %h want 000f", j, ck); else n_pass++;
      n_chk++; if (nb || xs !== 0) $display("FAIL nar_ser_n%0d got nb=%b xs=%0d want 0", j, nb, xs); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_msb_first();
    test_narrow();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tmds_serializer_gen.md
TMDS_SERIALIZER_GEN -- requirements
Module: tmds_serializer_gen

Interface
REQ-001: Parameter NUM_CH, default 3, number of serial data lanes (2..8).
REQ-002: Parameter WORD_W, default 10, bits per parallel word (even, 4..16).
REQ-003: Parameter MSB_FIRST, default 0; 0 = LSB transmitted first, 1 = MSB first.
REQ-004: Parameter IDLE_WORD, default 10'b1101010100, WORD_W bits, sent on every lane when no word is buffered.
REQ-005: clk_fast  input  1  bit-rate clock; the only clock in the block.
REQ-006: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007: in_data  input  NUM_CH*WORD_W  parallel words; lane k in bits [k*WORD_W +: WORD_W].
REQ-008: in_valid  input  1  in_data is valid this cycle.
REQ-009: in_ready  output  1  block accepts in_data this cycle.
REQ-010: underrun_clr  input  1  clears the sticky underrun flag.
REQ-011: ser_p  output  NUM_CH  serial data, lane k on bit k.
REQ-012: ser_n  output  NUM_CH  bitwise inverse of ser_p.
REQ-013: clk_p  output  1  forwarded word-rate clock.
REQ-014: clk_n  output  1  inverse of clk_p.
REQ-015: frame_strobe  output  1  one-cycle pulse marking the first bit of each word.
REQ-016: underrun  output  1  sticky flag: idle word inserted.

Function
REQ-017: bit_cnt counts 0..WORD_W-1 on each clk_fast edge and wraps to 0 after WORD_W-1.
REQ-018: Load edge: the edge where bit_cnt == WORD_W-1. At this edge every lane shift register loads a new word; on all other edges it shifts by one bit toward the output end, filling with 0.
REQ-019: Output end: bit 0 when MSB_FIRST=0, bit WORD_W-1 when MSB_FIRST=1. ser_p[k] is driven directly from the output end of lane k's shift register.
REQ-020: Input buffer: 2-entry FIFO of NUM_CH*WORD_W words. in_ready = FIFO not full. A push occurs when in_valid && in_ready.
REQ-021: At a load edge with the FIFO non-empty, the oldest entry is popped and loaded. With the FIFO empty, IDLE_WORD is loaded on every lane and underrun is set.
REQ-022: No bypass: a word pushed on a load edge into an empty FIFO is not loaded at that edge. It waits for the next load edge, and that load edge inserts IDLE_WORD.
REQ-023: Push and pop on the same edge leave the occupancy unchanged. Ordering is strictly FIFO.
REQ-024: underrun stays high until underrun_clr is sampled high. If a set and a clear occur on the same edge, the set wins.
REQ-025: frame_strobe is registered and is high in exactly the cycle after each load edge, i.e. while the first bit of the new word is on ser_p.
REQ-026: clk_p is registered. It is 1 while bit_cnt (post-edge) is in 0..WORD_W/2-1, and 0 otherwise, giving a 50% duty at clk_fast/WORD_W. Its rising edge is aligned with frame_strobe.
REQ-027: Latency from the push of a word into an empty, idle FIFO to its first bit on ser_p: at most 2*WORD_W cycles.
REQ-028: Deasserting in_valid while in_ready is low has no effect on buffered data.

Reset
REQ-029: While rst_n is low: bit_cnt=0, all shift registers=0, FIFO empty, in_ready=0, ser_p=0, ser_n=all 1, clk_p=0, clk_n=1, frame_strobe=0, underrun=0.
REQ-030: in_ready rises on the first clk_fast edge after rst_n deassertion. The first load edge is the WORD_W-th edge after deassertion, and zeros are output until then.
REQ-031: Assertion of rst_n mid-word discards the FIFO contents and the partial word immediately, without waiting for a clock edge.

Verification
REQ-032: Defaults. Push lane0=10'h3FF, lane1=0, lane2=10'h155 before the first load edge. Required: after the 10th edge, ser_p[0] is 1 for 10 cycles, ser_p[1] is 0, ser_p[2] alternates 1,0,1,... LSB first, and frame_strobe pulses once.
REQ-033: Hold in_valid high with 3 distinct words and no gaps. Required: in_ready drops when 2 words are buffered, words emerge in order, and underrun stays 0.
REQ-034: Stop feeding input. Required: the next load sends 1101010100 on all lanes, LSB first (0,0,1,0,1,0,1,0,1,1), underrun=1. Pulsing underrun_clr in a non-load cycle clears it.
REQ-035: MSB_FIRST=1 with word 10'h200. Required: ser_p shows 1 then 9 zeros. clk_p shows 5 high and 5 low cycles, with its rising edge coincident with frame_strobe.
REQ-036: Assert rst_n low at bit 4 of a word with 2 words buffered. Required: all outputs reach their REQ-029 values without a clock edge, and after release the first load is IDLE_WORD unless a new word is pushed first.
REQ-037: NUM_CH=4, WORD_W=8. Required: per-lane mapping is correct, the load period is 8 cycles, and ser_n equals ~ser_p every cycle.
